// File: rtl/memory_access.sv
// Memory stage of the RV32I pipeline: data-memory request/ready access with byte-lane
// steering and load extension, MEM/WB register, stall generation and branch redirect.
module memory_access #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  strCtrlM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        PCBranchM,
  input  logic        branchM,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] r2M,
  input  logic [31:0] PCplusImmM,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        stallM,
  output logic        misalignM,
  output logic        PCSrcM,
  output logic [31:0] PCTargetM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  state_t      nextState;
  logic [1:0]  off;
  logic [1:0]  offH;
  logic        accessPend;
  logic        isStore;
  logic        isLoad;
  logic        misaligned;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldExt;

  assign off        = ALUoutM[1:0];
  // Halfword lanes use the naturally aligned offset so an unchecked odd address stays in-word.
  assign offH       = {off[1], 1'b0};
  assign accessPend = MemWriteM | MemtoRegM;
  assign isStore    = MemWriteM;
  assign isLoad     = MemtoRegM & ~MemWriteM;

  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUoutM[31:2], 2'b00};
  assign PCSrcM    = PCBranchM & branchM;
  assign PCTargetM = PCplusImmM;

  always_comb begin
    misaligned = 1'b0;
    if (CHECK_ALIGN && accessPend) begin
      case (strCtrlM[1:0])
        2'b01:   misaligned = off[0];
        2'b10,
        2'b11:   misaligned = |off;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // FSM next state
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accessPend && !misaligned && !dmem_ready) nextState = WAIT;
      WAIT:    if (dmem_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs; reset forces the bus and stall low in the same cycle
  always_comb begin
    dmem_req  = 1'b0;
    stallM    = 1'b0;
    misalignM = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          dmem_req  = accessPend & ~misaligned;
          misalignM = misaligned;
        end
        WAIT:    dmem_req = 1'b1;
        default: dmem_req = 1'b0;
      endcase
      stallM = dmem_req & ~dmem_ready;
    end
  end

  // Store lane steering
  always_comb begin
    dmem_be    = 4'hF;
    dmem_wdata = r2M;
    if (isStore) begin
      case (strCtrlM[1:0])
        2'b00: begin
          dmem_be    = 4'(4'b0001 << off);
          dmem_wdata = {4{r2M[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'(4'b0011 << offH);
          dmem_wdata = {2{r2M[15:0]}};
        end
        default: begin
          dmem_be    = 4'hF;
          dmem_wdata = r2M;
        end
      endcase
    end
  end

  assign ldByte = 8'(dmem_rdata >> {off, 3'b000});
  assign ldHalf = 16'(dmem_rdata >> {offH, 3'b000});

  // Load lane select and extension
  always_comb begin
    ldExt = dmem_rdata;
    case (strCtrlM)
      3'b000:  ldExt = {{24{ldByte[7]}}, ldByte};
      3'b100:  ldExt = {24'b0, ldByte};
      3'b001:  ldExt = {{16{ldHalf[15]}}, ldHalf};
      3'b101:  ldExt = {16'b0, ldHalf};
      default: ldExt = dmem_rdata;
    endcase
  end

  // MEM/WB register: bubbles while stalled or on a suppressed access
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      rdW       <= 5'd0;
      ALUoutW   <= 32'd0;
      ReadDataW <= 32'd0;
    end else begin
      rdW     <= rdM;
      ALUoutW <= ALUoutM;
      if (stallM || misalignM) begin
        RegWriteW <= 1'b0;
        MemtoRegW <= 1'b0;
      end else begin
        RegWriteW <= RegWriteM & ~MemWriteM;
        MemtoRegW <= isLoad;
      end
      if (isLoad && dmem_req && dmem_ready) ReadDataW <= ldExt;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected W-stage results are queued as each
// instruction is driven and compared once the stage retires it.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  strCtrlM;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
  logic [4:0]  rdM;
  logic [31:0] ALUoutM, r2M, PCplusImmM;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        stallM, misalignM, PCSrcM;
  logic [31:0] PCTargetM;
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  rdW;
  logic [31:0] ALUoutW, ReadDataW;

  typedef struct packed {
    logic        regW;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } wExp_t;

  wExp_t       sb[$];
  logic [31:0] lastRead;
  int          nCmp = 0;
  int          nErr = 0;

  always #5 clk = ~clk;

  memory_access #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .strCtrlM(strCtrlM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCBranchM(PCBranchM), .branchM(branchM), .rdM(rdM),
    .ALUoutM(ALUoutM), .r2M(r2M), .PCplusImmM(PCplusImmM),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .stallM(stallM),
    .misalignM(misalignM), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .rdW(rdW),
    .ALUoutW(ALUoutW), .ReadDataW(ReadDataW)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setNop();
    strCtrlM = 3'b010; RegWriteM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
    PCBranchM = 1'b0; branchM = 1'b0; rdM = 5'd0; ALUoutM = 32'd0; r2M = 32'd0;
    PCplusImmM = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Drive one M-stage instruction (called just after a rising edge) and follow it to retirement.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic rw, input logic mw,
                       input logic mtr, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                       input logic [3:0] eBe, input logic [31:0] eWd, input logic eMis,
                       input logic [31:0] eRd);
    wExp_t e;
    int    reqN, stallN, misN;
    logic  acc, done;
    strCtrlM = f3; RegWriteM = rw; MemWriteM = mw; MemtoRegM = mtr;
    rdM = rd; ALUoutM = addr; r2M = wd;
    acc = mw | mtr;
    e.regW = rw & ~mw & ~eMis;
    e.m2r  = mtr & ~mw & ~eMis;
    e.rd   = rd;
    e.alu  = addr;
    if (mtr && !mw && !eMis) lastRead = eRd;
    e.rdata = lastRead;
    sb.push_back(e);
    reqN = 0; stallN = 0; misN = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem_ready = (cyc >= waits);
      dmem_rdata = dmem_ready ? rdata : $urandom;
      @(negedge clk);
      if (dmem_req) begin
        reqN++;
        checkVal({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        checkVal({tag, ".be"}, 32'(dmem_be), 32'(eBe));
        checkVal({tag, ".we"}, 32'(dmem_we), 32'(mw));
        if (mw) checkVal({tag, ".wdata"}, dmem_wdata, eWd);
      end
      if (stallM) stallN++;
      if (misalignM) misN++;
      @(posedge clk); #1;
      if (dmem_ready || !acc || eMis) done = 1'b1;
      else checkVal({tag, ".bubble"}, 32'(RegWriteW | MemtoRegW), 32'd0);
    end
    checkVal({tag, ".done"}, 32'(done), 32'd1);
    checkVal({tag, ".reqN"}, reqN, (acc && !eMis) ? waits + 1 : 0);
    checkVal({tag, ".stallN"}, stallN, (acc && !eMis) ? waits : 0);
    checkVal({tag, ".misN"}, misN, 32'(eMis));
    e = sb.pop_front();
    checkVal({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(e.regW));
    checkVal({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(e.m2r));
    checkVal({tag, ".rdW"}, 32'(rdW), 32'(e.rd));
    checkVal({tag, ".ALUoutW"}, ALUoutW, e.alu);
    checkVal({tag, ".ReadDataW"}, ReadDataW, e.rdata);
  endtask

  task automatic checkWZero(input string tag);
    checkVal({tag, ".RegWriteW"}, 32'(RegWriteW), 32'd0);
    checkVal({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'd0);
    checkVal({tag, ".rdW"}, 32'(rdW), 32'd0);
    checkVal({tag, ".ALUoutW"}, ALUoutW, 32'd0);
    checkVal({tag, ".ReadDataW"}, ReadDataW, 32'd0);
  endtask

  initial begin
    setNop();
    rst = 1'b0;
    MemtoRegM = 1'b1;
    lastRead = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkWZero("reset");
    @(negedge clk);
    checkVal("reset.req", 32'(dmem_req), 32'd0);
    checkVal("reset.stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    setNop();
    rst = 1'b1;

    runOp("lw",    3'b010, 1, 0, 1, 5'd1,  32'h100, 32'h0,        32'hDEADBEEF, 0, 4'hF,    32'h0,        0, 32'hDEADBEEF);
    runOp("lb",    3'b000, 1, 0, 1, 5'd2,  32'h103, 32'h0,        32'h80112233, 0, 4'hF,    32'h0,        0, 32'hFFFFFF80);
    runOp("lbu",   3'b100, 1, 0, 1, 5'd3,  32'h103, 32'h0,        32'h80112233, 0, 4'hF,    32'h0,        0, 32'h00000080);
    runOp("lhu",   3'b101, 1, 0, 1, 5'd4,  32'h102, 32'h0,        32'h80112233, 0, 4'hF,    32'h0,        0, 32'h00008011);
    runOp("lh_w2", 3'b001, 1, 0, 1, 5'd5,  32'h102, 32'h0,        32'h80112233, 2, 4'hF,    32'h0,        0, 32'hFFFF8011);
    runOp("sh",    3'b001, 0, 1, 0, 5'd6,  32'h006, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 0, 32'h0);
    runOp("sw_w3", 3'b010, 0, 1, 0, 5'd7,  32'h020, 32'hCAFEF00D, 32'h0,        3, 4'hF,    32'hCAFEF00D, 0, 32'h0);
    runOp("sb_w1", 3'b000, 0, 1, 0, 5'd8,  32'h041, 32'h000000A5, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0);
    runOp("alu",   3'b010, 1, 0, 0, 5'd9,  32'h1234, 32'h0,       32'h0,        0, 4'hF,    32'h0,        0, 32'h0);
    runOp("lw_mis",3'b010, 1, 0, 1, 5'd10, 32'h101, 32'h0,        32'h55555555, 0, 4'hF,    32'h0,        1, 32'h0);
    runOp("st_ld", 3'b010, 1, 1, 1, 5'd11, 32'h080, 32'h13572468, 32'h0,        0, 4'hF,    32'h13572468, 0, 32'h0);
    runOp("lbu1",  3'b100, 1, 0, 1, 5'd12, 32'h101, 32'h0,        32'h0000AB00, 0, 4'hF,    32'h0,        0, 32'h000000AB);
    setNop();

    // Reset while waiting on the bus abandons the request
    strCtrlM = 3'b010; RegWriteM = 1'b1; MemtoRegM = 1'b1; rdM = 5'd3; ALUoutM = 32'h200;
    dmem_ready = 1'b0;
    @(negedge clk);
    checkVal("rstwait.req0", 32'(dmem_req), 32'd1);
    checkVal("rstwait.stall0", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("rstwait.req", 32'(dmem_req), 32'd0);
    checkVal("rstwait.stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    checkWZero("rstwait");
    setNop();
    rst = 1'b1;
    lastRead = 32'd0;
    runOp("post_rst", 3'b010, 1, 0, 1, 5'd13, 32'h300, 32'h0, 32'h0BADF00D, 0, 4'hF, 32'h0, 0, 32'h0BADF00D);

    // Branch redirect is combinational and independent of the access path
    PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h200;
    #1;
    checkVal("br.PCSrcM", 32'(PCSrcM), 32'd1);
    checkVal("br.PCTargetM", PCTargetM, 32'h200);
    branchM = 1'b0;
    #1;
    checkVal("br.notaken", 32'(PCSrcM), 32'd0);
    setNop();
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
